// File: rtl/imem_boot_loader.sv
// Byte-stream boot loader: unpacks a length-prefixed big-endian program into instruction memory
// and holds the CPU in reset until it is loaded. Define IMEM_BOOT_LOADER_CHECKSUM_EN for a trailing XOR checksum byte.
module imem_boot_loader #(
    parameter int          IM_DEPTH  = 128,
    parameter logic [31:0] ADDR_BASE = 32'h0000_0000
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic [7:0]  byte_i,
    input  logic        byte_valid_i,
    output logic        byte_ready_o,
    output logic        im_we_o,
    output logic [31:0] im_addr_o,
    output logic [31:0] im_data_o,
    output logic        cpu_rst_n_o,
    output logic        done_o,
    output logic        err_o
);
    typedef enum logic [2:0] {
        CNT_HI,
        CNT_LO,
        DATA,
`ifdef IMEM_BOOT_LOADER_CHECKSUM_EN
        CSUM,
`endif
        DONE,
        ERR
    } state_t;

    localparam logic [16:0] DEPTH = 17'(IM_DEPTH);

    state_t      state;
    logic [15:0] n;
    logic [15:0] word_idx;
    logic [1:0]  bidx;
    logic [23:0] sbuf;
`ifdef IMEM_BOOT_LOADER_CHECKSUM_EN
    logic [7:0]  csum;
`endif

    logic accept;
    assign accept = byte_valid_i && byte_ready_o;

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state        <= CNT_HI;
            n            <= '0;
            word_idx     <= '0;
            bidx         <= '0;
            sbuf         <= '0;
`ifdef IMEM_BOOT_LOADER_CHECKSUM_EN
            csum         <= '0;
`endif
            byte_ready_o <= 1'b0;
            im_we_o      <= 1'b0;
            im_addr_o    <= '0;
            im_data_o    <= '0;
            cpu_rst_n_o  <= 1'b0;
            done_o       <= 1'b0;
            err_o        <= 1'b0;
        end else begin
            im_we_o      <= 1'b0;
            // Ready mirrors the state; transitions into DONE/ERR override it below.
            byte_ready_o <= (state != DONE) && (state != ERR);
            if (accept) begin
`ifdef IMEM_BOOT_LOADER_CHECKSUM_EN
                csum <= csum ^ byte_i;
`endif
                case (state)
                    CNT_HI: begin
                        n[15:8] <= byte_i;
                        state   <= CNT_LO;
                    end
                    CNT_LO: begin
                        n[7:0] <= byte_i;
                        if ({1'b0, n[15:8], byte_i} > DEPTH) begin
                            state        <= ERR;
                            err_o        <= 1'b1;
                            byte_ready_o <= 1'b0;
                        end else if ({n[15:8], byte_i} == 16'd0) begin
`ifdef IMEM_BOOT_LOADER_CHECKSUM_EN
                            state        <= CSUM;
`else
                            state        <= DONE;
                            done_o       <= 1'b1;
                            cpu_rst_n_o  <= 1'b1;
                            byte_ready_o <= 1'b0;
`endif
                        end else begin
                            state <= DATA;
                        end
                    end
                    DATA: begin
                        bidx <= bidx + 2'd1;
                        if (bidx == 2'd3) begin
                            im_we_o   <= 1'b1;
                            im_data_o <= {sbuf, byte_i};
                            im_addr_o <= ADDR_BASE + {14'd0, word_idx, 2'b00};
                            word_idx  <= word_idx + 16'd1;
                            if (word_idx == n - 16'd1) begin
`ifdef IMEM_BOOT_LOADER_CHECKSUM_EN
                                state        <= CSUM;
`else
                                state        <= DONE;
                                done_o       <= 1'b1;
                                cpu_rst_n_o  <= 1'b1;
                                byte_ready_o <= 1'b0;
`endif
                            end
                        end else begin
                            sbuf <= {sbuf[15:0], byte_i};
                        end
                    end
`ifdef IMEM_BOOT_LOADER_CHECKSUM_EN
                    CSUM: begin
                        byte_ready_o <= 1'b0;
                        if (byte_i == csum) begin
                            state       <= DONE;
                            done_o      <= 1'b1;
                            cpu_rst_n_o <= 1'b1;
                        end else begin
                            state <= ERR;
                            err_o <= 1'b1;
                        end
                    end
`endif
                    default: ;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_imem_boot_loader.sv
// Randomized bench for imem_boot_loader against a stream-level reference model.
module tb_imem_boot_loader;
    localparam int          DEPTH = 128;
    localparam logic [31:0] BASE  = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [7:0]  byte_d = 8'h00;
    logic        valid = 1'b0;
    logic        ready, we, cpu_rst_n, done, err;
    logic [31:0] addr, data;

    int checks = 0;
    int passes = 0;

    logic [7:0]  stream[$];
    logic [31:0] words[$];
    int          nw, term;
    bit          good;

    always #5 clk = ~clk;

    imem_boot_loader #(.IM_DEPTH(DEPTH), .ADDR_BASE(BASE)) dut (
        .clk_i(clk), .rst_i(rst_n), .byte_i(byte_d), .byte_valid_i(valid),
        .byte_ready_o(ready), .im_we_o(we), .im_addr_o(addr), .im_data_o(data),
        .cpu_rst_n_o(cpu_rst_n), .done_o(done), .err_o(err)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got === exp) passes++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    // Reference: words, index of the byte that ends the load, and the verdict.
    task automatic build_model();
        int n;
        logic [7:0] x;
        n = {stream[0], stream[1]};
        words.delete();
        if (n > DEPTH) begin
            nw = 0; term = 1; good = 0;
        end else begin
            nw = n;
            for (int i = 0; i < n; i++)
                words.push_back({stream[2+4*i], stream[3+4*i], stream[4+4*i], stream[5+4*i]});
`ifdef IMEM_BOOT_LOADER_CHECKSUM_EN
            x = 8'h00;
            for (int i = 0; i < 2 + 4*n; i++) x ^= stream[i];
            term = 2 + 4*n;
            good = (stream[term] == x);
`else
            x = 8'h00;
            term = 1 + 4*n;
            good = 1;
`endif
        end
    endtask

    task automatic add_tail(input bit corrupt);
        logic [7:0] x;
        x = 8'h00;
        foreach (stream[i]) x ^= stream[i];
`ifdef IMEM_BOOT_LOADER_CHECKSUM_EN
        stream.push_back(corrupt ? (x ^ 8'(1 + $urandom_range(0, 254))) : x);
`endif
        for (int i = 0; i < 4; i++) stream.push_back(8'($urandom));
    endtask

    task automatic make_prog(input int n, input bit corrupt);
        stream.delete();
        stream.push_back(8'(n >> 8));
        stream.push_back(8'(n));
        if (n <= DEPTH)
            for (int i = 0; i < 4*n; i++) stream.push_back(8'($urandom));
        add_tail(corrupt);
    endtask

    task automatic do_reset();
        valid = 1'b0;
        rst_n = 1'b0;
        #1;
        chk("rst_ready", ready, 0);
        chk("rst_we", we, 0);
        chk("rst_addr", addr, 0);
        chk("rst_data", data, 0);
        chk("rst_cpu", cpu_rst_n, 0);
        chk("rst_done", done, 0);
        chk("rst_err", err, 0);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Drives the stream; stop_at >= 0 returns early once that many bytes were taken.
    task automatic run(input bit gap, input int stop_at);
        int  idx = 0, last = -1, post = 0, wi;
        bit  fin = 0, ewe;
        int  budget = 8*stream.size() + 50;
        build_model();
        for (int cyc = 0; cyc < budget; cyc++) begin
            @(negedge clk);
            ewe = (last >= 2) && (last < 2 + 4*nw) && (((last - 2) % 4) == 3);
            chk("we", we, ewe);
            if (ewe) begin
                wi = (last - 2) / 4;
                chk("addr", addr, BASE + 32'(4*wi));
                chk("data", data, words[wi]);
            end
            if (last == term) fin = 1;
            chk("ready", ready, !fin);
            chk("done", done, fin && good);
            chk("err", err, fin && !good);
            chk("cpu_rst_n", cpu_rst_n, fin && good);
            if (fin && ++post > 3) break;
            if (stop_at >= 0 && idx >= stop_at) return;
            valid  = (idx < stream.size()) && (!gap || ($urandom_range(0, 1) == 1));
            byte_d = valid ? stream[idx] : 8'($urandom);
            last   = -1;
            if (valid && ready) begin
                last = idx;
                idx++;
            end
        end
        valid = 1'b0;
        chk("finish_in_budget", 32'(fin), 1);
    endtask

    task automatic basic();
        stream = '{8'h00, 8'h02, 8'h20, 8'h01, 8'h00, 8'h05, 8'h8C, 8'h02, 8'h00, 8'h04};
    endtask

    initial begin
        repeat (2) @(negedge clk);
        do_reset();

        basic(); add_tail(0); run(0, -1); do_reset();
        basic(); add_tail(0); run(1, -1); do_reset();
        basic(); add_tail(1); run(0, -1); do_reset();
        stream = '{8'h00, 8'h81, 8'h11, 8'h22}; run(0, -1); do_reset();
        stream = '{8'h00, 8'h00, 8'h00, 8'h33}; run(0, -1); do_reset();
        stream = '{8'h00, 8'h00, 8'h5A, 8'h33}; run(0, -1); do_reset();
        make_prog(DEPTH, 0); run(1, -1); do_reset();
        make_prog(DEPTH + 1, 0); run(0, -1); do_reset();

        basic(); add_tail(0); run(0, 6); do_reset();
        run(0, -1); do_reset();

        for (int t = 0; t < 24; t++) begin
            int kind = $urandom_range(0, 9);
            if (kind == 0) make_prog(DEPTH + 1 + $urandom_range(0, 60000), 0);
            else make_prog($urandom_range(0, 8), kind == 1);
            if (kind == 2) begin
                run($urandom_range(0, 1), $urandom_range(0, 12));
                do_reset();
            end
            run($urandom_range(0, 1), -1);
            do_reset();
        end

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
